// File: rtl/demux_reg_88.sv
// 1-to-8 registered demultiplexer: routes din to holding slot a..h selected by sel,
// with an independent valid/ack handshake per slot and a registered occupancy count.
module demux_reg_88 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       y_valid,
  input  logic [7:0]       y_ack,
  output logic [3:0]       count,
  output logic             full
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e      state_q [8];
  slot_state_e      state_d [8];
  logic [WIDTH-1:0] slot_q  [8];
  logic [7:0]       wr;
  logic [3:0]       count_q;
  logic [3:0]       count_d;
  logic             full_q;
  logic             accept;

  // A slot being acked this cycle is free to take new data in the same cycle.
  assign in_ready = ~y_valid[sel] | y_ack[sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    wr      = '0;
    count_d = count_q;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      // Short-circuit keeps an X on sel harmless while in_valid is low.
      wr[i] = accept && (sel == 3'(i));
      unique case (state_q[i])
        EMPTY: if (wr[i]) begin
          state_d[i] = FULL;
          count_d    = count_d + 4'd1;
        end
        FULL: if (y_ack[i] && !wr[i]) begin
          state_d[i] = EMPTY;
          count_d    = count_d - 4'd1;
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the slot array is reset explicitly because its contents are visible outputs.
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= EMPTY;
        slot_q[i]  <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= state_d[i];
        if (wr[i]) slot_q[i] <= din;
      end
      count_q <= count_d;
      full_q  <= (count_d == 4'd8);
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) y_valid[i] = (state_q[i] == FULL);
  end

  assign a     = slot_q[0];
  assign b     = slot_q[1];
  assign c     = slot_q[2];
  assign d     = slot_q[3];
  assign e     = slot_q[4];
  assign f     = slot_q[5];
  assign g     = slot_q[6];
  assign h     = slot_q[7];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: tb/tb_demux_reg_88.sv
// Self-checking bench for demux_reg_88: directed scenarios plus random traffic
// checked against a slot-array reference model.
module tb_demux_reg_88;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] sel;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c, d, e, f, g, h;
  logic [7:0] y_valid;
  logic [7:0] y_ack;
  logic [3:0] count;
  logic       full;

  int tests  = 0;
  int errors = 0;

  // Reference model: slot contents and occupancy flags.
  logic [7:0] m_data [8];
  bit         m_vld  [8];

  always #5 clk = ~clk;

  demux_reg_88 #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .y_valid(y_valid), .y_ack(y_ack), .count(count), .full(full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  function automatic logic [7:0] m_valid_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_vld[i];
    return v;
  endfunction

  function automatic bit m_ready(input logic [2:0] s, input logic [7:0] ack);
    return !m_vld[s] || ack[s];
  endfunction

  // Advance one clock: model applies the rules to the inputs seen at the edge.
  task automatic cycle();
    bit acc;
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin m_data[i] = 8'h00; m_vld[i] = 1'b0; end
    end else begin
      acc = in_valid && m_ready(sel, y_ack);
      for (int i = 0; i < 8; i++) if (y_ack[i]) m_vld[i] = 1'b0;
      if (acc) begin
        m_data[sel] = din;
        m_vld[sel]  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] outs [8];
    outs = '{a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) check($sformatf("%s_slot%0d", tag, i), 32'(outs[i]), 32'(m_data[i]));
    check({tag, "_y_valid"}, 32'(y_valid), 32'(m_valid_vec()));
    check({tag, "_count"}, 32'(count), 32'(m_count()));
    check({tag, "_full"}, 32'(full), 32'(m_count() == 8));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    sel      = 3'd0;
    din      = 8'h00;
    in_valid = 1'b0;
    y_ack    = 8'h00;
    for (int i = 0; i < 8; i++) begin m_data[i] = 8'h00; m_vld[i] = 1'b0; end
    @(negedge clk);

    // Reset then idle
    do_reset();
    check("reset_y_valid", 32'(y_valid), 32'h00);
    check("reset_count", 32'(count), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check_all("reset");
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1 check($sformatf("reset_ready_sel%0d", i), 32'(in_ready), 32'd1);
    end

    // Fill all slots
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      din = 8'h10 + 8'(i);
      #1 check($sformatf("fill_ready%0d", i), 32'(in_ready), 32'd1);
      cycle();
    end
    in_valid = 1'b0;
    check("fill_y_valid", 32'(y_valid), 32'hFF);
    check("fill_count", 32'(count), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    check("fill_a", 32'(a), 32'h10);
    check("fill_h", 32'(h), 32'h17);
    check_all("fill");

    // Blocked write to a full slot
    sel = 3'd3; din = 8'hAA; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check("blocked_ready", 32'(in_ready), 32'd0);
      cycle();
      check("blocked_d", 32'(d), 32'h13);
      check("blocked_count", 32'(count), 32'd8);
    end

    // Same-cycle refill
    y_ack = 8'h08; din = 8'h55;
    #1 check("refill_ready", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0; y_ack = 8'h00;
    check("refill_d", 32'(d), 32'h55);
    check("refill_y_valid3", 32'(y_valid[3]), 32'd1);
    check("refill_count", 32'(count), 32'd8);
    check_all("refill");

    // Multi-ack
    y_ack = 8'b1010_0101;
    cycle();
    check("multi_y_valid", 32'(y_valid), 32'h5A);
    check("multi_count", 32'(count), 32'd4);
    check("multi_full", 32'(full), 32'd0);
    check("multi_a", 32'(a), 32'h10);
    check("multi_c", 32'(c), 32'h12);
    check("multi_f", 32'(f), 32'h15);
    check("multi_h", 32'(h), 32'h17);
    y_ack = 8'h01;
    cycle();
    y_ack = 8'h00;
    check("stray_y_valid", 32'(y_valid), 32'h5A);
    check("stray_count", 32'(count), 32'd4);
    check_all("stray");

    // Random traffic, including X on sel while idle
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din      = 8'($urandom);
      y_ack    = 8'($urandom) & 8'($urandom);
      if (!in_valid && $urandom_range(0, 3) == 0) sel = 3'bx;
      else begin
        sel = 3'($urandom_range(0, 7));
        #1 check("rand_ready", 32'(in_ready), 32'(m_ready(sel, y_ack)));
      end
      cycle();
      check_all("rand");
    end
    in_valid = 1'b0; y_ack = 8'h00; sel = 3'd0;

    // Reset mid-operation with count=5
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i); din = 8'hC0 + 8'(i);
      cycle();
    end
    check("pre_reset_count", 32'(count), 32'd5);
    sel = 3'd6; din = 8'hFF; reset_n = 1'b0;
    cycle();
    reset_n = 1'b1; in_valid = 1'b0;
    check("midreset_y_valid", 32'(y_valid), 32'h00);
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_g", 32'(g), 32'h00);
    check_all("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
